// File: rtl/matrix_transpose.sv
// Streaming ping-pong transposer: frames arrive row-major and leave column-major.
// Two banks alternate so that one frame is written while the previous one is read.
module matrix_transpose #(
   parameter int unsigned ADDR_WIDTH = 18,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ROW        = 64,
   parameter int unsigned CLO        = 2400
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_treaty
);

   localparam int unsigned FrameWords = ROW * CLO;
   localparam int unsigned IdxW       = (FrameWords > 1) ? $clog2(FrameWords) : 1;
   localparam logic [ADDR_WIDTH-1:0] LastWord = ADDR_WIDTH'(FrameWords - 1);
   localparam logic [ADDR_WIDTH-1:0] LastRow  = ADDR_WIDTH'(ROW - 1);
   localparam logic [ADDR_WIDTH-1:0] LastCol  = ADDR_WIDTH'(CLO - 1);
   localparam logic [ADDR_WIDTH-1:0] ColStep  = ADDR_WIDTH'(CLO);

   typedef enum logic [0:0] {StIdle, StRead} rd_state_e;

   rd_state_e             rd_state_q, rd_state_d;
   logic                  init_q;
   logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic                  wr_bank_q, wr_bank_d;
   logic [1:0]            full_q, full_d;
   logic                  rd_bank_q, rd_bank_d;
   logic [ADDR_WIDTH-1:0] rd_row_q, rd_row_d;
   logic [ADDR_WIDTH-1:0] rd_col_q, rd_col_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic [DATA_WIDTH-1:0] rdata_q, out_data_q;
   logic                  rvalid_q, out_valid_q;
   logic                  wr_fire, wr_last, rd_fire, rd_done, rd_last, rd_en, out_ready;

   logic [DATA_WIDTH-1:0] mem [2][FrameWords];

   // init_q keeps the input closed until the first edge after reset release.
   assign s_axis_tready = init_q && !full_q[wr_bank_q];
   assign wr_fire       = s_axis_tvalid && s_axis_tready;
   assign wr_last       = (wr_cnt_q == LastWord);
   assign rd_last       = (rd_row_q == LastRow) && (rd_col_q == LastCol);

   // Read-data register and output register form the 2-entry buffer; a read is
   // issued only when the word it produces has somewhere to go.
   assign out_ready     = !out_valid_q || m_axis_treaty;
   assign rd_en         = !rvalid_q || out_ready;
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tvalid = out_valid_q;

   always_comb begin
      wr_cnt_d  = wr_cnt_q;
      wr_bank_d = wr_bank_q;
      full_d    = full_q;
      if (rd_done) full_d[rd_bank_q] = 1'b0;
      if (wr_fire) begin
         if (wr_last) begin
            wr_cnt_d          = '0;
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_bank_d  = rd_bank_q;
      rd_row_d   = rd_row_q;
      rd_col_d   = rd_col_q;
      rd_addr_d  = rd_addr_q;
      rd_fire    = 1'b0;
      rd_done    = 1'b0;
      unique case (rd_state_q)
         StIdle: begin
            if (full_q[rd_bank_q] && rd_en) begin
               rd_fire    = 1'b1;
               rd_state_d = StRead;
            end
         end
         StRead: begin
            if (rd_en) rd_fire = 1'b1;
         end
         default: rd_state_d = StIdle;
      endcase
      // Address accumulator: step by a row within a column, restart at the next column.
      if (rd_fire) begin
         if (rd_last) begin
            rd_row_d   = '0;
            rd_col_d   = '0;
            rd_addr_d  = '0;
            rd_done    = 1'b1;
            rd_bank_d  = ~rd_bank_q;
            rd_state_d = StIdle;
         end else if (rd_row_q == LastRow) begin
            rd_row_d  = '0;
            rd_col_d  = rd_col_q + 1'b1;
            rd_addr_d = rd_col_q + 1'b1;
         end else begin
            rd_row_d  = rd_row_q + 1'b1;
            rd_addr_d = rd_addr_q + ColStep;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_bank_q][wr_cnt_q[IdxW-1:0]] <= s_axis_tdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         init_q      <= 1'b0;
         wr_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         full_q      <= '0;
         rd_state_q  <= StIdle;
         rd_bank_q   <= 1'b0;
         rd_row_q    <= '0;
         rd_col_q    <= '0;
         rd_addr_q   <= '0;
         rdata_q     <= '0;
         rvalid_q    <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         init_q     <= 1'b1;
         wr_cnt_q   <= wr_cnt_d;
         wr_bank_q  <= wr_bank_d;
         full_q     <= full_d;
         rd_state_q <= rd_state_d;
         rd_bank_q  <= rd_bank_d;
         rd_row_q   <= rd_row_d;
         rd_col_q   <= rd_col_d;
         rd_addr_q  <= rd_addr_d;
         if (rd_fire) begin
            rdata_q  <= mem[rd_bank_q][rd_addr_q[IdxW-1:0]];
            rvalid_q <= 1'b1;
         end else if (out_ready) begin
            rvalid_q <= 1'b0;
         end
         if (out_ready) begin
            out_valid_q <= rvalid_q;
            if (rvalid_q) out_data_q <= rdata_q;
         end
      end
   end

endmodule

// File: tb/tb_matrix_transpose.sv
// Directed bench for matrix_transpose with a 2x3 frame: ordering, latency,
// back-to-back streaming, backpressure, bank-full stall, mid-frame reset and input gaps.
module tb_matrix_transpose;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 2;
   localparam int unsigned NC = 3;

   logic          clk;
   logic          rst;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;

   int            checks;
   int            errors;
   int            cyc = 0;
   int            last_acc_edge;
   int            first_rx_cyc;
   int            last_rx_cyc;
   int            rdy_low;
   bit            watch_rdy;
   logic [DW-1:0] tx_q[$];
   logic [DW-1:0] rx_q[$];

   matrix_transpose #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .ROW       (NR),
      .CLO       (NC)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_axis_tdata (s_data),
      .s_axis_tvalid(s_valid),
      .s_axis_tready(s_ready),
      .m_axis_tdata (m_data),
      .m_axis_tvalid(m_valid),
      .m_axis_treaty(m_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Collects output beats, checks hold-stability under backpressure, watches tready.
   task automatic monitor();
      bit            hold_chk;
      logic [DW-1:0] hold_data;
      hold_chk  = 1'b0;
      hold_data = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            hold_chk = 1'b0;
         end else begin
            if (hold_chk) begin
               checks++;
               if (m_valid !== 1'b1 || m_data !== hold_data) begin
                  errors++;
                  $display("FAIL hold_stable: got valid=%0b data=%0d, want valid=1 data=%0d",
                           m_valid, m_data, hold_data);
               end
            end
            hold_chk  = m_valid && !m_ready;
            hold_data = m_data;
            if (m_valid && m_ready) begin
               if (rx_q.size() == 0) first_rx_cyc = cyc;
               rx_q.push_back(m_data);
               last_rx_cyc = cyc;
            end
            if (watch_rdy && !s_ready) rdy_low++;
         end
      end
   endtask

   // Sends everything in tx_q; gap_pct is the chance of an idle cycle. Entered at posedge+1.
   task automatic drive_all(input int gap_pct);
      int stall;
      stall = 0;
      while (tx_q.size() > 0) begin
         s_valid = ($urandom_range(0, 99) >= gap_pct);
         s_data  = tx_q[0];
         @(negedge clk);
         if (s_valid && s_ready) begin
            void'(tx_q.pop_front());
            last_acc_edge = cyc + 1;
            stall = 0;
         end else begin
            stall++;
            if (stall > 200) begin
               checks++;
               errors++;
               $display("FAIL drive_timeout: got no accept in %0d cycles, want accept", stall);
               tx_q.delete();
            end
         end
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_rx(input string name, input int n);
      int budget;
      budget = 0;
      while (rx_q.size() < n && budget < 400) begin
         @(posedge clk);
         #1;
         budget++;
      end
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      checks++;
      if (rx_q.size() != n) begin
         errors++;
         $display("FAIL %s_count: got %0d words, want %0d", name, rx_q.size(), n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks += 3;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_tready: got %0b, want 0", s_ready);
      end
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_tvalid: got %0b, want 0", m_valid);
      end
      if (m_data !== '0) begin
         errors++;
         $display("FAIL reset_tdata: got %0d, want 0", m_data);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL tready_before_edge: got %0b, want 0", s_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         errors++;
         $display("FAIL tready_after_edge: got %0b, want 1", s_ready);
      end
   endtask

   task automatic test_basic();
      logic [DW-1:0] exp[6] = '{0, 3, 1, 4, 2, 5};
      logic [DW-1:0] got;
      rx_q.delete();
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) tx_q.push_back(DW'(i));
      drive_all(0);
      wait_rx("basic", 6);
      for (int i = 0; i < 6; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 'x;
         checks++;
         if (got !== exp[i]) begin
            errors++;
            $display("FAIL basic[%0d]: got %0d, want %0d", i, got, exp[i]);
         end
      end
      checks++;
      if (first_rx_cyc - last_acc_edge != 2) begin
         errors++;
         $display("FAIL basic_latency: got %0d cycles, want 2", first_rx_cyc - last_acc_edge);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] exp_a[6] = '{0, 0, 1, 1, 2, 2};
      logic [DW-1:0] exp_b[6] = '{3, 3, 2, 2, 1, 1};
      logic [DW-1:0] got;
      logic [DW-1:0] want;
      rx_q.delete();
      rdy_low = 0;
      for (int f = 0; f < 5; f++)
         for (int r = 0; r < int'(NR); r++)
            for (int c = 0; c < int'(NC); c++)
               tx_q.push_back((f % 2 == 0) ? DW'(c) : DW'(int'(NC) - c));
      watch_rdy = 1'b1;
      drive_all(0);
      watch_rdy = 1'b0;
      wait_rx("b2b", 30);
      for (int i = 0; i < 30; i++) begin
         got  = (i < rx_q.size()) ? rx_q[i] : 'x;
         want = ((i / 6) % 2 == 0) ? exp_a[i % 6] : exp_b[i % 6];
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL b2b[%0d]: got %0d, want %0d", i, got, want);
         end
      end
      checks += 2;
      if (rdy_low != 0) begin
         errors++;
         $display("FAIL b2b_tready: got %0d low cycles, want 0", rdy_low);
      end
      if (last_rx_cyc - first_rx_cyc != 29) begin
         errors++;
         $display("FAIL b2b_bubble: got span %0d, want 29", last_rx_cyc - first_rx_cyc);
      end
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] got;
      logic [DW-1:0] want;
      int            f;
      int            j;
      rx_q.delete();
      for (int i = 0; i < 24; i++) tx_q.push_back(DW'(100 + i));
      fork
         drive_all(0);
         begin
            for (int i = 0; i < 150; i++) begin
               m_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
            m_ready = 1'b1;
         end
      join
      wait_rx("bp", 24);
      for (int i = 0; i < 24; i++) begin
         f    = i / 6;
         j    = i % 6;
         want = DW'(100 + f * 6 + (j % 2) * 3 + j / 2);
         got  = (i < rx_q.size()) ? rx_q[i] : 'x;
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL bp[%0d]: got %0d, want %0d", i, got, want);
         end
      end
   endtask

   task automatic test_stall_fill();
      logic [DW-1:0] exp[18] = '{200, 203, 201, 204, 202, 205, 206, 209, 207, 210, 208, 211,
                                 212, 215, 213, 216, 214, 217};
      logic [DW-1:0] got;
      int            blocked;
      rx_q.delete();
      m_ready = 1'b0;
      for (int i = 0; i < 12; i++) tx_q.push_back(DW'(200 + i));
      drive_all(0);
      s_valid = 1'b1;
      s_data  = 212;
      blocked = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (!s_ready) blocked++;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      checks += 2;
      if (blocked != 6) begin
         errors++;
         $display("FAIL stall_tready_low: got %0d low cycles, want 6", blocked);
      end
      if (rx_q.size() != 0) begin
         errors++;
         $display("FAIL stall_no_output: got %0d words, want 0", rx_q.size());
      end
      m_ready = 1'b1;
      for (int i = 12; i < 18; i++) tx_q.push_back(DW'(200 + i));
      drive_all(0);
      wait_rx("stall", 18);
      for (int i = 0; i < 18; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 'x;
         checks++;
         if (got !== exp[i]) begin
            errors++;
            $display("FAIL stall[%0d]: got %0d, want %0d", i, got, exp[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] exp[6] = '{400, 403, 401, 404, 402, 405};
      logic [DW-1:0] got;
      rx_q.delete();
      m_ready = 1'b1;
      for (int i = 0; i < 9; i++) tx_q.push_back(DW'(300 + i));
      drive_all(0);
      checks++;
      if (m_valid !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre_valid: got %0b, want 1", m_valid);
      end
      #2 rst = 1'b0;
      #1;
      checks += 3;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_tvalid: got %0b, want 0", m_valid);
      end
      if (m_data !== '0) begin
         errors++;
         $display("FAIL rstmid_tdata: got %0d, want 0", m_data);
      end
      if (s_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_tready: got %0b, want 0", s_ready);
      end
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rx_q.delete();
      for (int i = 0; i < 6; i++) tx_q.push_back(DW'(400 + i));
      drive_all(0);
      wait_rx("rstmid", 6);
      for (int i = 0; i < 6; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 'x;
         checks++;
         if (got !== exp[i]) begin
            errors++;
            $display("FAIL rstmid[%0d]: got %0d, want %0d", i, got, exp[i]);
         end
      end
   endtask

   task automatic test_gaps();
      logic [DW-1:0] exp[6] = '{500, 503, 501, 504, 502, 505};
      logic [DW-1:0] got;
      rx_q.delete();
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) tx_q.push_back(DW'(500 + i));
      drive_all(40);
      wait_rx("gaps", 6);
      for (int i = 0; i < 6; i++) begin
         got = (i < rx_q.size()) ? rx_q[i] : 'x;
         checks++;
         if (got !== exp[i]) begin
            errors++;
            $display("FAIL gaps[%0d]: got %0d, want %0d", i, got, exp[i]);
         end
      end
      checks++;
      if (first_rx_cyc - last_acc_edge != 2) begin
         errors++;
         $display("FAIL gaps_latency: got %0d cycles, want 2", first_rx_cyc - last_acc_edge);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      s_valid   = 1'b0;
      s_data    = '0;
      m_ready   = 1'b1;
      watch_rdy = 1'b0;
      rdy_low   = 0;
      fork
         monitor();
      join_none
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_stall_fill();
      test_reset_mid();
      test_gaps();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
